// File: rtl/vending_controller.sv
// vending_controller
//   Coin-operated vend controller. Credit is kept in nickel units. When the
//   credit reaches PRICE, the controller dispenses one product. Any remainder
//   is then paid back as change over several cycles, dimes first and then at
//   most one nickel. It also handles cancel/refund, a sold-out inhibit, a
//   credit ceiling with coin rejection, and a busy flag for the acceptor.
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-high
//   nickel         one-cycle pulse, coin worth 1 unit
//   dime           one-cycle pulse, coin worth 2 units
//   quarter        one-cycle pulse, coin worth 5 units
//   cancel         one-cycle pulse, refund request
//   sold_out       level, blocks vending and coin acceptance
//   product        registered one-cycle dispense pulse
//   change_dime    registered one-cycle pulse, return one dime
//   change_nickel  registered one-cycle pulse, return one nickel
//   coin_reject    registered one-cycle pulse, coin returned uncredited
//   busy           registered, high while change is being paid out
//   credit         current credit in nickel units
module vending_controller #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                sold_out,
    output logic                product,
    output logic                change_dime,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic {IDLE, CHANGE} state_t;

    // One extra bit so that credit + coin can never wrap before the ceiling test.
    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                product_next, change_dime_next, change_nickel_next;
    logic                coin_reject_next, busy_next;

    logic                any_coin;
    logic [1:0]          coin_count;
    logic [2:0]          coin_value;
    logic [CREDIT_W:0]   credit_x, coin_sum, vend_left;

    assign any_coin   = nickel | dime | quarter;
    assign coin_count = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
    assign credit_x   = {1'b0, credit};
    assign coin_sum   = credit_x + (CREDIT_W+1)'(coin_value);
    assign vend_left  = credit_x - PRICE_X;

    // The value only matters when exactly one coin line is high.
    always_comb begin
        coin_value = 3'd0;
        if (quarter)
            coin_value = 3'd5;
        else if (dime)
            coin_value = 3'd2;
        else if (nickel)
            coin_value = 3'd1;
    end

    always_comb begin
        state_next         = state;
        credit_next        = credit;
        product_next       = 1'b0;
        change_dime_next   = 1'b0;
        change_nickel_next = 1'b0;
        coin_reject_next   = 1'b0;
        busy_next          = 1'b0;

        case (state)
            IDLE: begin
                if (cancel) begin
                    coin_reject_next = any_coin;
                    if (credit != '0) begin
                        state_next = CHANGE;
                        busy_next  = 1'b1;
                    end
                end else if (credit_x >= PRICE_X && !sold_out) begin
                    product_next     = 1'b1;
                    coin_reject_next = any_coin;
                    credit_next      = vend_left[CREDIT_W-1:0];
                    if (vend_left != '0) begin
                        state_next = CHANGE;
                        busy_next  = 1'b1;
                    end
                end else if (any_coin) begin
                    if (coin_count > 2'd1 || sold_out || coin_sum > MAX_X)
                        coin_reject_next = 1'b1;
                    else
                        credit_next = coin_sum[CREDIT_W-1:0];
                end
            end

            CHANGE: begin
                // Cancel is ignored here. Coins are always bounced.
                coin_reject_next = any_coin;
                if (credit >= CREDIT_W'(2)) begin
                    change_dime_next = 1'b1;
                    credit_next      = credit - CREDIT_W'(2);
                end else if (credit != '0) begin
                    change_nickel_next = 1'b1;
                    credit_next        = '0;
                end
                // Busy drops on the same edge that the last coin of change goes out.
                if (credit_next == '0)
                    state_next = IDLE;
                else
                    busy_next = 1'b1;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            product       <= 1'b0;
            change_dime   <= 1'b0;
            change_nickel <= 1'b0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            credit        <= credit_next;
            product       <= product_next;
            change_dime   <= change_dime_next;
            change_nickel <= change_nickel_next;
            coin_reject   <= coin_reject_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller
//   Bench for vending_controller. Instance a uses PRICE=3, MAX_CREDIT=20.
//   Instance b uses PRICE=20, MAX_CREDIT=20. Directed tables cover the main
//   scenarios. A randomized run on instance a is compared cycle by cycle
//   against a behavioural model of the vend rules.
module tb_vending_controller;

    localparam int P_A  = 3;
    localparam int MAXC = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1, nickel_a = 1'b0, dime_a = 1'b0, quarter_a = 1'b0;
    logic       cancel_a = 1'b0, sold_out_a = 1'b0;
    logic       product_a, change_dime_a, change_nickel_a, coin_reject_a, busy_a;
    logic [4:0] credit_a;

    logic       reset_b = 1'b1, nickel_b = 1'b0, dime_b = 1'b0, quarter_b = 1'b0;
    logic       cancel_b = 1'b0, sold_out_b = 1'b0;
    logic       product_b, change_dime_b, change_nickel_b, coin_reject_b, busy_b;
    logic [4:0] credit_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vending_controller #(.PRICE(P_A), .MAX_CREDIT(MAXC), .CREDIT_W(5)) dut_a (
        .clk(clk), .reset(reset_a), .nickel(nickel_a), .dime(dime_a),
        .quarter(quarter_a), .cancel(cancel_a), .sold_out(sold_out_a),
        .product(product_a), .change_dime(change_dime_a),
        .change_nickel(change_nickel_a), .coin_reject(coin_reject_a),
        .busy(busy_a), .credit(credit_a)
    );

    vending_controller #(.PRICE(20), .MAX_CREDIT(MAXC), .CREDIT_W(5)) dut_b (
        .clk(clk), .reset(reset_b), .nickel(nickel_b), .dime(dime_b),
        .quarter(quarter_b), .cancel(cancel_b), .sold_out(sold_out_b),
        .product(product_b), .change_dime(change_dime_b),
        .change_nickel(change_nickel_b), .coin_reject(coin_reject_b),
        .busy(busy_b), .credit(credit_b)
    );

    // Stimulus word: {reset, nickel, dime, quarter, cancel, sold_out}
    // Observation word: {product, change_dime, change_nickel, coin_reject, busy, credit[4:0]}
    task automatic drive_a(input logic [5:0] s);
        {reset_a, nickel_a, dime_a, quarter_a, cancel_a, sold_out_a} = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic [5:0] s);
        {reset_b, nickel_b, dime_b, quarter_b, cancel_b, sold_out_b} = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] obs_a();
        return {product_a, change_dime_a, change_nickel_a, coin_reject_a, busy_a, credit_a};
    endfunction

    function automatic logic [9:0] obs_b();
        return {product_b, change_dime_b, change_nickel_b, coin_reject_b, busy_b, credit_b};
    endfunction

    task automatic test_reset();
        logic [5:0] st [3];
        logic [9:0] ex [3];
        st = '{6'b111111, 6'b101010, 6'b000000};
        ex = '{10'd0, 10'd0, 10'd0};
        for (int i = 0; i < 3; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL reset_a step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
        total_cnt++;
        if (obs_b() !== 10'd0)
            $display("FAIL reset_b: got %b want %b", obs_b(), 10'd0);
        else
            pass_cnt++;
        reset_b = 1'b0;
    endtask

    task automatic test_nickels();
        logic [5:0] st [5];
        logic [9:0] ex [5];
        st = '{6'b010000, 6'b010000, 6'b010000, 6'b000000, 6'b000000};
        ex = '{{5'b00000, 5'd1}, {5'b00000, 5'd2}, {5'b00000, 5'd3},
               {5'b10000, 5'd0}, {5'b00000, 5'd0}};
        for (int i = 0; i < 5; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL nickels step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_dimes();
        logic [5:0] st [5];
        logic [9:0] ex [5];
        st = '{6'b001000, 6'b001000, 6'b000000, 6'b000000, 6'b000000};
        ex = '{{5'b00000, 5'd2}, {5'b00000, 5'd4}, {5'b10001, 5'd1},
               {5'b00100, 5'd0}, {5'b00000, 5'd0}};
        for (int i = 0; i < 5; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL dimes step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_quarter();
        logic [5:0] st [4];
        logic [9:0] ex [4];
        st = '{6'b000100, 6'b000000, 6'b000000, 6'b000000};
        ex = '{{5'b00000, 5'd5}, {5'b10001, 5'd2}, {5'b01000, 5'd0}, {5'b00000, 5'd0}};
        for (int i = 0; i < 4; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL quarter step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_errors();
        logic [5:0] st [13];
        logic [9:0] ex [13];
        st = '{6'b011000, 6'b000100, 6'b000000, 6'b010000, 6'b000010,
               6'b001000, 6'b000010, 6'b000000, 6'b010000, 6'b010010,
               6'b000000, 6'b000000, 6'b001100};
        ex = '{{5'b00010, 5'd0}, {5'b00000, 5'd5}, {5'b10001, 5'd2},
               {5'b01010, 5'd0}, {5'b00000, 5'd0}, {5'b00000, 5'd2},
               {5'b00001, 5'd2}, {5'b01000, 5'd0}, {5'b00000, 5'd1},
               {5'b00011, 5'd1}, {5'b00100, 5'd0}, {5'b00000, 5'd0},
               {5'b00010, 5'd0}};
        for (int i = 0; i < 13; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL errors step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_sold_out();
        logic [5:0] st [9];
        logic [9:0] ex [9];
        st = '{6'b000101, 6'b010000, 6'b001000, 6'b000001, 6'b010001,
               6'b000011, 6'b000001, 6'b000001, 6'b000000};
        ex = '{{5'b00010, 5'd0}, {5'b00000, 5'd1}, {5'b00000, 5'd3},
               {5'b00000, 5'd3}, {5'b00010, 5'd3}, {5'b00001, 5'd3},
               {5'b01001, 5'd1}, {5'b00100, 5'd0}, {5'b00000, 5'd0}};
        for (int i = 0; i < 9; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL sold_out step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] st [7];
        logic [9:0] ex [7];
        st = '{6'b001000, 6'b000100, 6'b000000, 6'b000000,
               6'b100000, 6'b000000, 6'b000000};
        ex = '{{5'b00000, 5'd2}, {5'b00000, 5'd7}, {5'b10001, 5'd4},
               {5'b01001, 5'd2}, 10'd0, 10'd0, 10'd0};
        for (int i = 0; i < 7; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL reset_mid step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] st [7];
        logic [9:0] ex [7];
        st = '{6'b000100, 6'b000100, 6'b000000, 6'b010000,
               6'b010000, 6'b010000, 6'b000000};
        ex = '{{5'b00000, 5'd5}, {5'b10011, 5'd2}, {5'b01000, 5'd0},
               {5'b00000, 5'd1}, {5'b00000, 5'd2}, {5'b00000, 5'd3},
               {5'b10000, 5'd0}};
        for (int i = 0; i < 7; i++) begin
            drive_a(st[i]);
            total_cnt++;
            if (obs_a() !== ex[i])
                $display("FAIL back_to_back step %0d: got %b want %b", i, obs_a(), ex[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_price20();
        logic [5:0] st [16];
        logic [9:0] ex [16];
        int dimes = 0, nickels = 0, cyc = 0;
        st = '{6'b000101, 6'b000101, 6'b000101, 6'b000101,
               6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000000,
               6'b000100, 6'b000100, 6'b000100,
               6'b001000, 6'b001000, 6'b001000, 6'b000010};
        ex = '{{5'b00010, 5'd0}, {5'b00010, 5'd0}, {5'b00010, 5'd0}, {5'b00010, 5'd0},
               {5'b00000, 5'd5}, {5'b00000, 5'd10}, {5'b00000, 5'd15}, {5'b00000, 5'd20},
               {5'b10000, 5'd0},
               {5'b00000, 5'd5}, {5'b00000, 5'd10}, {5'b00000, 5'd15},
               {5'b00000, 5'd17}, {5'b00000, 5'd19}, {5'b00010, 5'd19},
               {5'b00001, 5'd19}};
        for (int i = 0; i < 16; i++) begin
            drive_b(st[i]);
            total_cnt++;
            if (obs_b() !== ex[i])
                $display("FAIL price20 step %0d: got %b want %b", i, obs_b(), ex[i]);
            else
                pass_cnt++;
        end
        // A refund of 19 units should come back as nine dimes and one nickel.
        while (busy_b === 1'b1 && cyc < 40) begin
            drive_b(6'b000000);
            cyc++;
            dimes   += int'(change_dime_b);
            nickels += int'(change_nickel_b);
        end
        total_cnt++;
        if (busy_b !== 1'b0)
            $display("FAIL price20_drain_timeout: busy=%b after %0d cycles, want 0", busy_b, cyc);
        else
            pass_cnt++;
        total_cnt++;
        if (dimes != 9)
            $display("FAIL price20_dimes: got %0d want 9", dimes);
        else
            pass_cnt++;
        total_cnt++;
        if (nickels != 1)
            $display("FAIL price20_nickels: got %0d want 1", nickels);
        else
            pass_cnt++;
        total_cnt++;
        if (credit_b !== 5'd0)
            $display("FAIL price20_final_credit: got %0d want 0", credit_b);
        else
            pass_cnt++;
    endtask

    task automatic test_random();
        int  mc = 0;
        bit  mchg = 1'b0;
        bit  so = 1'b0;
        bit  r, n, d, q, c;
        bit  ep, ed, en, er, eb;
        int  nc, v;
        logic [9:0] ex;
        drive_a(6'b100000);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom % 60) == 0;
            n = ($urandom % 5) == 0;
            d = ($urandom % 5) == 0;
            q = ($urandom % 6) == 0;
            c = ($urandom % 12) == 0;
            if (($urandom % 25) == 0)
                so = !so;
            drive_a({r, n, d, q, c, so});

            ep = 0; ed = 0; en = 0; er = 0; eb = 0;
            nc = int'(n) + int'(d) + int'(q);
            v  = int'(n) + 2 * int'(d) + 5 * int'(q);
            if (r) begin
                mc = 0;
                mchg = 0;
            end else if (mchg) begin
                er = nc > 0;
                if (mc >= 2) begin
                    ed = 1;
                    mc -= 2;
                end else if (mc == 1) begin
                    en = 1;
                    mc = 0;
                end
                mchg = mc > 0;
                eb = mchg;
            end else if (c) begin
                er = nc > 0;
                if (mc > 0) begin
                    mchg = 1;
                    eb = 1;
                end
            end else if (mc >= P_A && !so) begin
                ep = 1;
                er = nc > 0;
                mc -= P_A;
                mchg = mc > 0;
                eb = mchg;
            end else if (nc > 0) begin
                if (nc > 1 || so || mc + v > MAXC)
                    er = 1;
                else
                    mc += v;
            end
            ex = {ep, ed, en, er, eb, 5'(mc)};

            total_cnt++;
            if (obs_a() !== ex) begin
                $display("FAIL random cycle %0d: got %b want %b", i, obs_a(), ex);
                // Resynchronise the model so that one fault does not cascade.
                mc = int'(credit_a);
                mchg = busy_a;
            end else
                pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_nickels();
        test_dimes();
        test_quarter();
        test_errors();
        test_sold_out();
        test_reset_mid();
        test_back_to_back();
        test_price20();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
